delay_detect: RTL and testbench

//  Receive-side partner to the programmable delay line. Given a reference

---
 rtl/delay_detect.sv | 170 +++++++++++++++++
 tb/tb_delay_detect.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/delay_detect.sv
// delay_detect: searches candidate delays 0..2^LGDLY-1 for the offset at which
// a delayed copy of a reference stream matches the reference, locks onto it,
// and emits the reference re-aligned to the delayed stream.
module delay_detect #(
   parameter int LGDLY       = 4,
   parameter int DW          = 12,
   parameter int LGCNT       = 4,
   parameter int MATCH_COUNT = 8,
   parameter int LOSS_COUNT  = 4
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_ce,
   input  logic [DW-1:0]    i_word,
   input  logic [DW-1:0]    i_delayed,
   output logic [LGDLY-1:0] o_delay,
   output logic             o_locked,
   output logic [DW-1:0]    o_aligned,
   output logic             o_wrap
);

   // hist[k] holds the reference word from k+1 accepted samples ago
   localparam int NHIST = (1 << LGDLY) - 1;
   localparam logic [LGCNT:0] MATCH_TGT = (LGCNT+1)'(MATCH_COUNT);
   localparam logic [LGCNT:0] LOSS_TGT  = (LGCNT+1)'(LOSS_COUNT);

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [LGDLY-1:0] d_q, d_d;
   logic [LGCNT-1:0] mcnt_q, mcnt_d;
   logic [LGCNT-1:0] lcnt_q, lcnt_d;
   logic [LGDLY-1:0] fill_q, fill_d;
   logic [DW-1:0]    hist_q [NHIST];
   logic [DW-1:0]    hist_d [NHIST];
   logic             locked_q, locked_d;
   logic [DW-1:0]    aligned_q, aligned_d;
   logic             wrap_q, wrap_d;

   logic [LGDLY-1:0] d_prev;
   logic [DW-1:0]    ref_word;
   logic             cmp_valid;
   logic             cmp_match;
   logic [LGCNT:0]   mcnt_inc;
   logic [LGCNT:0]   lcnt_inc;

   // Select the reference word for the current candidate delay and compare it
   always_comb begin
      d_prev = d_q - LGDLY'(1);
      if (d_q == '0) begin
         ref_word = i_word;
      end else begin
         ref_word = hist_q[d_prev];
      end
      // A delay is only testable once the history is deep enough to hold it
      cmp_valid = (fill_q >= d_q);
      cmp_match = (i_delayed == ref_word);
      mcnt_inc  = {1'b0, mcnt_q} + (LGCNT+1)'(1);
      lcnt_inc  = {1'b0, lcnt_q} + (LGCNT+1)'(1);
   end

   // Next-state logic: history shift, fill count, search / lock state machine
   always_comb begin
      state_d   = state_q;
      d_d       = d_q;
      mcnt_d    = mcnt_q;
      lcnt_d    = lcnt_q;
      fill_d    = fill_q;
      hist_d    = hist_q;
      locked_d  = locked_q;
      aligned_d = aligned_q;
      wrap_d    = 1'b0;

      if (i_ce) begin
         hist_d[0] = i_word;
         for (int k = 1; k < NHIST; k++) begin
            hist_d[k] = hist_q[k-1];
         end
         if (fill_q != '1) begin
            fill_d = fill_q + LGDLY'(1);
         end else begin
            fill_d = fill_q;
         end
         aligned_d = ref_word;

         if (cmp_valid) begin
            case (state_q)
               ST_SEARCH: begin
                  if (cmp_match) begin
                     if (mcnt_inc == MATCH_TGT) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                        mcnt_d   = '0;
                        lcnt_d   = '0;
                     end else begin
                        mcnt_d = mcnt_inc[LGCNT-1:0];
                     end
                  end else begin
                     // Move on to the next candidate; flag a full sweep with no lock
                     mcnt_d = '0;
                     d_d    = d_q + LGDLY'(1);
                     wrap_d = (d_q == '1);
                  end
               end
               ST_LOCKED: begin
                  if (cmp_match) begin
                     lcnt_d = '0;
                  end else if (lcnt_inc == LOSS_TGT) begin
                     // Drop lock but keep d so the search resumes where it was
                     state_d  = ST_SEARCH;
                     locked_d = 1'b0;
                     lcnt_d   = '0;
                     mcnt_d   = '0;
                  end else begin
                     lcnt_d = lcnt_inc[LGCNT-1:0];
                  end
               end
               default: begin
                  state_d  = ST_SEARCH;
                  locked_d = 1'b0;
                  mcnt_d   = '0;
                  lcnt_d   = '0;
               end
            endcase
         end else begin
            state_d = state_q;
         end
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q   <= ST_SEARCH;
         d_q       <= '0;
         mcnt_q    <= '0;
         lcnt_q    <= '0;
         fill_q    <= '0;
         locked_q  <= 1'b0;
         aligned_q <= '0;
         wrap_q    <= 1'b0;
         for (int k = 0; k < NHIST; k++) begin
            hist_q[k] <= '0;
         end
      end else begin
         state_q   <= state_d;
         d_q       <= d_d;
         mcnt_q    <= mcnt_d;
         lcnt_q    <= lcnt_d;
         fill_q    <= fill_d;
         locked_q  <= locked_d;
         aligned_q <= aligned_d;
         wrap_q    <= wrap_d;
         for (int k = 0; k < NHIST; k++) begin
            hist_q[k] <= hist_d[k];
         end
      end
   end

   assign o_delay   = d_q;
   assign o_locked  = locked_q;
   assign o_aligned = aligned_q;
   assign o_wrap    = wrap_q;

endmodule

// File: tb/tb_delay_detect.sv
// Testbench for delay_detect: table of lock scenarios plus directed sequences
// for sweep wrap, loss of lock / relock and mid-search reset.
module tb_delay_detect;

   localparam int LGDLY = 4;
   localparam int DW    = 12;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             ce = 1'b0;
   logic [DW-1:0]    word = '0;
   logic [DW-1:0]    dly_in = '0;
   logic [LGDLY-1:0] o_delay;
   logic             o_locked;
   logic [DW-1:0]    o_aligned;
   logic             o_wrap;

   int n_cmp = 0;
   int n_err = 0;
   int g = 0;              // accepted-sample index of the external stream
   int cur_dly = 0;        // delay of the modelled external delay line
   bit uncorr = 1'b0;      // 1: delayed stream shares no value with the reference
   logic [DW-1:0] last_delayed = '0;

   typedef struct {
      int dly;
      int ce_per;
      int exp_lock;
   } vec_t;

   vec_t tbl [5];

   delay_detect dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_ce      (ce),
      .i_word    (word),
      .i_delayed (dly_in),
      .o_delay   (o_delay),
      .o_locked  (o_locked),
      .o_aligned (o_aligned),
      .o_wrap    (o_wrap)
   );

   always #5 clk = ~clk;

   // Reference words are even and pairwise distinct over 2048 samples
   function automatic logic [DW-1:0] word_of(input int k);
      logic [31:0] t;
      t = k * 74 + 2;
      return t[DW-1:0];
   endfunction

   // Odd values never equal any reference word, so no delay can match
   function automatic logic [DW-1:0] delayed_of(input int k);
      if (uncorr) return word_of(k) | 12'h001;
      else if (k >= cur_dly) return word_of(k - cur_dly);
      else return 12'h001;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input bit ce_v);
      ce     = ce_v;
      word   = word_of(g);
      dly_in = delayed_of(g);
      @(posedge clk);
      #1;
      last_delayed = dly_in;
      if (ce_v) g++;
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      ce     = 1'b1;
      word   = word_of(g);
      dly_in = delayed_of(g);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_delay",   int'(o_delay),   0);
      check("rst_locked",  int'(o_locked),  0);
      check("rst_aligned", int'(o_aligned), 0);
      check("rst_wrap",    int'(o_wrap),    0);
   endtask

   // Run ce pulses (every ce_per clocks) until lock; idle clocks must not move outputs
   task automatic run_to_lock(input int ce_per, input int budget,
                              output int cnt, output bit ok);
      logic [LGDLY+DW:0] snap;
      cnt = 0;
      ok  = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         for (int z = 1; z < ce_per; z++) begin
            snap = {o_delay, o_locked, o_aligned};
            step(1'b0);
            check("idle_stable", int'({o_delay, o_locked, o_aligned}), int'(snap));
            check("idle_wrap", int'(o_wrap), 0);
         end
         step(1'b1);
         cnt++;
         if (o_locked) ok = 1'b1;
      end
      if (!ok) cnt = 999;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      bit ok;

      // dly, ce period, ce count at which o_locked first reads 1 (dly + 8)
      tbl[0] = '{dly: 0,  ce_per: 1, exp_lock: 8};
      tbl[1] = '{dly: 5,  ce_per: 1, exp_lock: 13};
      tbl[2] = '{dly: 3,  ce_per: 3, exp_lock: 11};
      tbl[3] = '{dly: 15, ce_per: 1, exp_lock: 23};
      tbl[4] = '{dly: 1,  ce_per: 2, exp_lock: 9};

      repeat (2) @(posedge clk);
      #1;

      // Lock scenarios from reset
      for (int s = 0; s < 5; s++) begin
         uncorr  = 1'b0;
         cur_dly = tbl[s].dly;
         do_reset();
         run_to_lock(tbl[s].ce_per, 60, cnt, ok);
         check("lock_ce_count", cnt, tbl[s].exp_lock);
         check("lock_delay", int'(o_delay), tbl[s].dly);
         for (int j = 0; j < 4; j++) begin
            step(1'b1);
            check("aligned_eq_delayed", int'(o_aligned), int'(last_delayed));
            check("stays_locked", int'(o_locked), 1);
         end
      end

      // Uncorrelated stream: delay sweeps 0..15 and wraps, never locks
      uncorr = 1'b1;
      do_reset();
      for (int n = 1; n <= 40; n++) begin
         step(1'b1);
         check("sweep_delay", int'(o_delay), n % 16);
         check("sweep_wrap", int'(o_wrap), (n % 16 == 0) ? 1 : 0);
         check("sweep_unlocked", int'(o_locked), 0);
      end

      // Locked at 5, line switches to 9: lock lost on 4th mismatch, relock at 9
      uncorr  = 1'b0;
      cur_dly = 5;
      do_reset();
      run_to_lock(1, 60, cnt, ok);
      check("sw_first_lock", cnt, 13);
      cur_dly = 9;
      for (int i = 1; i <= 4; i++) begin
         step(1'b1);
         check("sw_locked", int'(o_locked), (i < 4) ? 1 : 0);
         check("sw_delay_held", int'(o_delay), 5);
      end
      run_to_lock(1, 60, cnt, ok);
      check("sw_relock_ce", cnt, 12);
      check("sw_relock_delay", int'(o_delay), 9);

      // Reset mid-search at d=7, then relock from a fresh history fill
      uncorr = 1'b1;
      do_reset();
      for (int i = 0; i < 7; i++) step(1'b1);
      check("mid_delay", int'(o_delay), 7);
      do_reset();
      uncorr  = 1'b0;
      cur_dly = 12;
      run_to_lock(1, 60, cnt, ok);
      check("post_rst_lock_ce", cnt, 20);
      check("post_rst_delay", int'(o_delay), 12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
